// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for a minimal RV32I core: fetches over a valid/ready
// handshake, classifies the opcode, raises one ALU sub-unit enable for the
// execute/writeback window, strobes the register-file write and owns the PC.
module alu_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned INSTRET_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     run,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic [31:0]              instruction,
  output logic [6:0]               alu_enable,
  input  logic                     next_pc_valid,
  input  logic [31:0]              next_pc,
  output logic                     rf_write_enable,
  output logic [4:0]               rf_rd,
  output logic [31:0]              pc,
  output logic                     illegal_instruction,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    StIdle,
    StFetchReq,
    StFetchWait,
    StDecode,
    StExecute,
    StWriteback,
    StTrap
  } state_e;

  state_e                   state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [31:0]              instr_q, instr_d;
  logic [6:0]               alu_en_q, alu_en_d;
  logic                     illegal_q, illegal_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

  logic [6:0] decoded;
  logic       is_ctrl;
  logic       redirect;
  logic       misaligned;

  // Opcode to one-hot sub-unit enable; zero means the opcode is not supported.
  function automatic logic [6:0] decode_opcode(input logic [6:0] opcode);
    logic [6:0] en;
    en = 7'b0;
    case (opcode)
      7'b0110011: en = 7'b0000001; // reg-reg
      7'b0010011: en = 7'b0000010; // reg-imm
      7'b1100011: en = 7'b0000100; // branch
      7'b1101111: en = 7'b0001000; // jal
      7'b1100111: en = 7'b0010000; // jalr
      7'b0110111: en = 7'b0100000; // lui
      7'b0010111: en = 7'b1000000; // auipc
      default:    en = 7'b0;
    endcase
    return en;
  endfunction

  // Redirect qualification: next_pc_valid only matters for control-flow ops.
  always_comb begin
    decoded    = decode_opcode(instr_q[6:0]);
    is_ctrl    = |alu_en_q[4:2];
    redirect   = is_ctrl && next_pc_valid;
    misaligned = redirect && (next_pc[1:0] != 2'b00);
  end

  // Next-state, datapath register updates and handshake/strobe outputs.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    alu_en_d        = alu_en_q;
    illegal_d       = illegal_q;
    instret_d       = instret_q;
    imem_req_valid  = 1'b0;
    rf_write_enable = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetchReq;
      end
      StFetchReq: begin
        // Held until accepted; address comes straight from pc_q so it cannot move.
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = StFetchWait;
      end
      StFetchWait: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (decoded == 7'b0) begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end else begin
          alu_en_d = decoded;
          state_d  = StExecute;
        end
      end
      StExecute: begin
        state_d = StWriteback;
      end
      StWriteback: begin
        alu_en_d = 7'b0;
        if (misaligned) begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end else begin
          rf_write_enable = !alu_en_q[2] && (instr_q[11:7] != 5'd0);
          pc_d            = redirect ? next_pc : pc_q + 32'd4;
          instret_d       = instret_q + INSTRET_WIDTH'(1);
          state_d         = run ? StFetchReq : StIdle;
        end
      end
      StTrap: begin
        // Sticky until reset.
        state_d = StTrap;
      end
      default: begin
        state_d = StTrap;
      end
    endcase
  end

  // State and architectural registers; reset asserts asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= 32'b0;
      alu_en_q  <= 7'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      alu_en_q  <= alu_en_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  assign imem_req_addr       = pc_q;
  assign instruction         = instr_q;
  assign alu_enable          = alu_en_q;
  assign rf_rd               = instr_q[11:7];
  assign pc                  = pc_q;
  assign illegal_instruction = illegal_q;
  assign instret             = instret_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control FSM for the minimal RV32I core. It fetches an instruction over a valid/ready memory handshake and classifies the opcode. It then raises exactly one ALU sub-unit enable for the execute/writeback window, drives register-file write control and owns the architectural PC. It sits between instruction memory, the register file and the ALU datapath, which holds the branch, jal, jalr, lui, auipc, reg-imm and reg-reg units.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
INSTRET_WIDTH, 32, width of retired-instruction counter

Ports:
clock  input  1  core clock, rising edge
reset_n  input  1  asynchronous active-low reset
run  input  1  1 = fetch and execute; 0 = stop at next instruction boundary
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  fetch address (= pc)
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  fetch data valid
imem_rsp_data  input  32  fetched instruction
instruction  output  32  latched instruction to decode/ALU
alu_enable  output  7  one-hot: [0] reg-reg, [1] reg-imm, [2] branch, [3] jal, [4] jalr, [5] lui, [6] auipc
next_pc_valid  input  1  ALU redirect valid (taken branch/jal/jalr)
next_pc  input  32  ALU redirect target
rf_write_enable  output  1  register-file write strobe
rf_rd  output  5  destination register index (instruction[11:7])
pc  output  32  architectural PC
illegal_instruction  output  1  sticky trap flag
instret  output  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, instruction=0, alu_enable=0, rf_write_enable=0, imem_req_valid=0, illegal_instruction=0, instret=0.
- States: IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK, TRAP.
- IDLE: go to FETCH_REQ when run=1.
- FETCH_REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Hold both until imem_req_ready=1, then go to FETCH_WAIT.
  - Request must not drop or change while ready=0.
- FETCH_WAIT:
  - On imem_rsp_valid=1, latch imem_rsp_data into instruction and go to DECODE.
  - A rsp_valid in any other state is ignored.
- DECODE: map opcode instruction[6:0] to an alu_enable bit, registered for the next cycle.
  - 0110011 → [0]; 0010011 → [1]; 1100011 → [2]; 1101111 → [3]; 1100111 → [4]; 0110111 → [5]; 0010111 → [6].
  - Any other opcode → TRAP. alu_enable stays 0 and illegal_instruction=1.
- EXECUTE: alu_enable held one-hot, one cycle, for ALU evaluation. Go to WRITEBACK.
- WRITEBACK: alu_enable still held; at end of cycle alu_enable returns to 0.
  - rf_write_enable=1 for one cycle unless the op is branch or rf_rd==0.
  - PC update:
    - If enable is branch/jal/jalr and next_pc_valid=1: pc<=next_pc.
    - Otherwise pc<=pc+4, wrapping mod 2^32 (0xFFFF_FFFC+4 = 0).
  - Misaligned redirect (next_pc_valid=1 and next_pc[1:0]!=0): go to TRAP. pc unchanged, no rf write, instret unchanged.
  - Otherwise instret<=instret+1 (wraps). Next state is FETCH_REQ if run=1, else IDLE.
- next_pc_valid is ignored for non-control ops.
- TRAP: sticky. All outputs idle, pc frozen, illegal_instruction=1. Exit only by reset.
- run=0 mid-instruction does not abort; the current instruction retires first.
- Reset mid-fetch: request dropped immediately. Memory must tolerate an abandoned request.
- Latency: response accepted → rf_write_enable at 3rd cycle (DECODE, EXECUTE, WRITEBACK). Minimum 5 cycles per instruction with zero-wait memory.
- At most one alu_enable bit high at any time; rf_write_enable only in WRITEBACK.

Test Plan:
- Reset, run=1, zero-wait memory, ADDI x1 (0x00500093) at pc 0 → req at addr 0; alu_enable=7'b0000010 for 2 cycles; rf_write_enable=1 with rf_rd=1; pc=4; instret=1; next req addr 4.
- BEQ at pc 8, next_pc_valid=1, next_pc=0x20 → alu_enable[2] set, no rf write, pc=0x20. Repeat with next_pc_valid=0 → pc=0xC.
- JAL x0 with next_pc=0x100 → rf_write_enable stays 0 (rd=0), pc=0x100, instret increments.
- imem_req_ready low 3 cycles, then rsp after 2 more → req_valid/addr stable throughout; instruction latched only on rsp_valid; latency counts from rsp.
- Illegal opcode 0x0000007F → TRAP, illegal_instruction=1, no further requests, pc frozen. JALR with next_pc=0x102 → TRAP, pc unchanged.
- run dropped during EXECUTE → instruction retires, FSM enters IDLE. Reset asserted in FETCH_WAIT → all outputs return to reset values asynchronously, pc=RESET_PC.
